// File: rtl/gemm_pkg.sv
// Shared constants and types for the GEMM MMIO controller: register offsets,
// CTRL/STATUS bit positions and the sequencer state encoding.
package gemm_pkg;

  localparam logic [4:0] CTRL_OFF   = 5'h00;
  localparam logic [4:0] STATUS_OFF = 5'h04;
  localparam logic [4:0] SRC_A_OFF  = 5'h08;
  localparam logic [4:0] SRC_B_OFF  = 5'h0C;
  localparam logic [4:0] DST_OFF    = 5'h10;
  localparam logic [4:0] DIM_OFF    = 5'h14;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_DONE_BIT     = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_PUSH,
    ST_COLLECT,
    ST_DONE
  } gemm_state_e;

endpackage

// File: rtl/gemm_core_if.sv
// Core memory-stage access bus into the controller's register window.
interface gemm_core_if #(
  parameter int ADDR_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic              core_sel;
  logic [31:0]       core_rdata;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_sel, core_rdata
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_sel, core_rdata
  );
endinterface

// File: rtl/gemm_regfile.sv
// Register window: address decode, configuration storage with writes locked
// while a run is in progress, CTRL strobes and same-cycle load data.
module gemm_regfile
  import gemm_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  gemm_core_if.slave        core,
  input  logic              busy,
  input  logic              done,
  output logic [ADDR_W-1:0] src_a,
  output logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] dst,
  output logic [CNT_W-1:0]  dim,
  output logic              start,
  output logic              clr_done
);

  logic [ADDR_W-1:0] src_a_reg, src_b_reg, dst_reg;
  logic [CNT_W-1:0]  dim_reg;
  logic [4:0]        off;
  logic              wr, cfg_wr, ctrl_wr;

  // Window is 32-byte aligned, so the hit test only looks at the upper bits.
  assign core.core_sel = core.core_req &&
                         (core.core_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign off     = core.core_addr[4:0];
  assign wr      = core.core_sel && core.core_we;
  assign cfg_wr  = wr && !busy;
  assign ctrl_wr = wr && (off == CTRL_OFF);

  // START is dropped while busy; CLR_DONE always goes through.
  assign start    = ctrl_wr && core.core_wdata[CTRL_START_BIT] && !busy;
  assign clr_done = ctrl_wr && core.core_wdata[CTRL_CLR_DONE_BIT];

  assign src_a = src_a_reg;
  assign src_b = src_b_reg;
  assign dst   = dst_reg;
  assign dim   = dim_reg;

  // Configuration registers, frozen while the sequencer runs.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_a_reg <= '0;
      src_b_reg <= '0;
      dst_reg   <= '0;
      dim_reg   <= '0;
    end else if (cfg_wr) begin
      case (off)
        SRC_A_OFF: src_a_reg <= core.core_wdata[ADDR_W-1:0];
        SRC_B_OFF: src_b_reg <= core.core_wdata[ADDR_W-1:0];
        DST_OFF:   dst_reg   <= core.core_wdata[ADDR_W-1:0];
        DIM_OFF:   dim_reg   <= core.core_wdata[CNT_W-1:0];
        default:   ;
      endcase
    end
  end

  // Load data is returned in the same cycle; CTRL and unmapped offsets read 0.
  always_comb begin
    core.core_rdata = '0;
    if (core.core_sel) begin
      case (off)
        STATUS_OFF: begin
          core.core_rdata[STAT_BUSY_BIT] = busy;
          core.core_rdata[STAT_DONE_BIT] = done;
        end
        SRC_A_OFF: core.core_rdata = 32'(src_a_reg);
        SRC_B_OFF: core.core_rdata = 32'(src_b_reg);
        DST_OFF:   core.core_rdata = 32'(dst_reg);
        DIM_OFF:   core.core_rdata = 32'(dim_reg);
        default:   core.core_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/gemm_mmio_ctrl.sv
// GEMM command sequencer: streams N A/B row pairs from memory into the
// systolic array, writes N result words back, then raises DONE/IRQ.
module gemm_mmio_ctrl
  import gemm_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  gemm_core_if.slave        core,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              arr_valid,
  input  logic              arr_ready,
  output logic [31:0]       arr_a,
  output logic [31:0]       arr_b,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [31:0]       res_data,
  output logic              irq
);

  gemm_state_e       state_reg;
  logic [CNT_W-1:0]  i_reg, k_reg, i_next, k_next;
  logic              push_first_reg;
  logic              done_reg;
  logic              busy, start, clr_done;
  logic [ADDR_W-1:0] src_a, src_b, dst;
  logic [CNT_W-1:0]  dim;

  assign busy   = (state_reg != ST_IDLE);
  assign irq    = done_reg;
  assign i_next = i_reg + CNT_W'(1);
  assign k_next = k_reg + CNT_W'(1);

  // Byte offset of row idx, computed at address width so it wraps naturally.
  function automatic logic [ADDR_W-1:0] row_off(input logic [CNT_W-1:0] idx);
    return ADDR_W'({idx, 2'b00});
  endfunction

  gemm_regfile #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .CNT_W     (CNT_W)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .core     (core),
    .busy     (busy),
    .done     (done_reg),
    .src_a    (src_a),
    .src_b    (src_b),
    .dst      (dst),
    .dim      (dim),
    .start    (start),
    .clr_done (clr_done)
  );

  // Sequencer FSM; all memory/array outputs are registered here and set up
  // on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      i_reg          <= '0;
      k_reg          <= '0;
      push_first_reg <= 1'b0;
      done_reg       <= 1'b0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      arr_valid      <= 1'b0;
      arr_a          <= '0;
      arr_b          <= '0;
      res_ready      <= 1'b0;
    end else begin
      if (clr_done) done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            done_reg <= 1'b0;
            i_reg    <= '0;
            k_reg    <= '0;
            if (dim == '0) begin
              state_reg <= ST_DONE;
            end else begin
              state_reg <= ST_RD_A;
              mem_en    <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= src_a;
            end
          end
        end
        ST_RD_A: begin
          state_reg <= ST_RD_B;
          mem_addr  <= src_b + row_off(i_reg);
        end
        ST_RD_B: begin
          // A word issued in RD_A returns now.
          arr_a          <= mem_rdata;
          mem_en         <= 1'b0;
          push_first_reg <= 1'b1;
          state_reg      <= ST_PUSH;
        end
        ST_PUSH: begin
          if (push_first_reg) begin
            arr_b          <= mem_rdata;
            arr_valid      <= 1'b1;
            push_first_reg <= 1'b0;
          end else if (arr_valid && arr_ready) begin
            arr_valid <= 1'b0;
            i_reg     <= i_next;
            if (i_next == dim) begin
              state_reg <= ST_COLLECT;
              res_ready <= 1'b1;
            end else begin
              state_reg <= ST_RD_A;
              mem_en    <= 1'b1;
              mem_addr  <= src_a + row_off(i_next);
            end
          end
        end
        ST_COLLECT: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (res_valid && res_ready) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= dst + row_off(k_reg);
            mem_wdata <= res_data;
            k_reg     <= k_next;
            if (k_next == dim) begin
              res_ready <= 1'b0;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
